// File: rtl/pcs_40g_rx_lane_sync.sv
// Per-lane 40GBASE-R receive synchronizer: block lock (sync-header hunting with
// gearbox bit-slip requests) followed by alignment-marker lock that identifies
// the logical lane carried on this physical lane.
// Optional build macro PCS_RX_ERR_CNT_EN adds err_cnt_o, a saturating count of
// invalid sync headers seen while block lock is held.
module pcs_40g_rx_lane_sync #(
    parameter int unsigned LANE_N      = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned HEAD_W      = 2,
    parameter int unsigned AM_SPACING  = 16383,
    parameter int unsigned SH_CNT_N    = 64,
    parameter int unsigned SH_INVLD_N  = 16,
    parameter int unsigned SLIP_WAIT_N = 2
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    input  logic [HEAD_W-1:0]         head_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic                      slip_o,
    output logic                      valid_o,
    output logic [HEAD_W-1:0]         head_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      block_lock_o,
    output logic                      am_lock_o,
    output logic [$clog2(LANE_N)-1:0] lane_id_o,
    output logic                      am_v_o
`ifdef PCS_RX_ERR_CNT_EN
    ,
    output logic [15:0]               err_cnt_o
`endif
);

    localparam int unsigned LaneW   = $clog2(LANE_N);
    localparam int unsigned ShCntW  = $clog2(SH_CNT_N + 1);
    localparam int unsigned InvldW  = $clog2(SH_INVLD_N + 1);
    localparam int unsigned WaitW   = (SLIP_WAIT_N > 0) ? $clog2(SLIP_WAIT_N + 1) : 1;
    localparam int unsigned PosW    = $clog2(AM_SPACING + 1);
    // Only four marker patterns exist; wider lane counts cannot match more.
    localparam int unsigned AmLaneN = (LANE_N < 4) ? LANE_N : 4;

    localparam logic [HEAD_W-1:0] HeadData = HEAD_W'(1);
    localparam logic [HEAD_W-1:0] HeadCtrl = HEAD_W'(2);

    localparam logic [1:0] AmSearch  = 2'd0;
    localparam logic [1:0] AmConfirm = 2'd1;
    localparam logic [1:0] AmLocked  = 2'd2;

    // {M2, M1, M0} for each logical lane
    function automatic logic [23:0] am_pattern(input int unsigned lane);
        case (lane)
            0:       am_pattern = 24'h47_76_90;
            1:       am_pattern = 24'hE6_C4_F0;
            2:       am_pattern = 24'h9B_65_C5;
            default: am_pattern = 24'h3D_79_A2;
        endcase
    endfunction

    // Registers
    logic              r_valid;
    logic [HEAD_W-1:0] r_head;
    logic [DATA_W-1:0] r_data;
    logic              r_slip;
    logic              r_block_lock;
    logic [ShCntW-1:0] r_sh_cnt;
    logic [InvldW-1:0] r_sh_invld;
    logic [WaitW-1:0]  r_slip_wait;
    logic [1:0]        r_am_state;
    logic [PosW-1:0]   r_pos;
    logic [LaneW-1:0]  r_cand_id;
    logic [1:0]        r_miss_cnt;
    logic              r_am_lock;
    logic [LaneW-1:0]  r_lane_id;
    logic              r_am_v;

    // Next-state wires
    logic              w_hdr_ok;
    logic              w_eval;
    logic [ShCntW-1:0] w_sh_cnt_inc;
    logic [InvldW-1:0] w_sh_invld_inc;
    logic              w_slip_nxt;
    logic              w_block_lock_nxt;
    logic              w_lock_drop;
    logic [ShCntW-1:0] w_sh_cnt_nxt;
    logic [InvldW-1:0] w_sh_invld_nxt;
    logic [WaitW-1:0]  w_slip_wait_nxt;
    logic              w_am_match;
    logic [LaneW-1:0]  w_am_id;
    logic              w_pos_exp;
    logic [1:0]        w_am_state_nxt;
    logic [PosW-1:0]   w_pos_nxt;
    logic [LaneW-1:0]  w_cand_id_nxt;
    logic [1:0]        w_miss_cnt_nxt;
    logic              w_am_lock_nxt;
    logic [LaneW-1:0]  w_lane_id_nxt;
    logic              w_am_v_nxt;

    assign w_hdr_ok       = (head_i == HeadData) || (head_i == HeadCtrl);
    // The block right after a slip is never evaluated, so slips cannot repeat back to back.
    assign w_eval         = valid_i && (r_slip_wait == '0) && !r_slip;
    assign w_sh_cnt_inc   = r_sh_cnt + ShCntW'(1);
    assign w_sh_invld_inc = r_sh_invld + (w_hdr_ok ? InvldW'(0) : InvldW'(1));
    assign w_pos_exp      = (r_pos == PosW'(AM_SPACING));

    // Block lock: sync-header window counting, slip requests and slip-wait discard
    always_comb begin
        w_slip_nxt       = 1'b0;
        w_block_lock_nxt = r_block_lock;
        w_lock_drop      = 1'b0;
        w_sh_cnt_nxt     = r_sh_cnt;
        w_sh_invld_nxt   = r_sh_invld;
        w_slip_wait_nxt  = r_slip_wait;
        if (valid_i && !w_eval) begin
            if (r_slip_wait != '0) begin
                w_slip_wait_nxt = r_slip_wait - WaitW'(1);
            end
        end else if (w_eval && !r_block_lock) begin
            if (!w_hdr_ok) begin
                w_slip_nxt      = 1'b1;
                w_sh_cnt_nxt    = '0;
                w_sh_invld_nxt  = '0;
                w_slip_wait_nxt = WaitW'(SLIP_WAIT_N);
            end else if (w_sh_cnt_inc == ShCntW'(SH_CNT_N)) begin
                w_block_lock_nxt = 1'b1;
                w_sh_cnt_nxt     = '0;
                w_sh_invld_nxt   = '0;
            end else begin
                w_sh_cnt_nxt = w_sh_cnt_inc;
            end
        end else if (w_eval) begin
            // Invalid-count threshold is checked first so it beats the window reset.
            if (w_sh_invld_inc == InvldW'(SH_INVLD_N)) begin
                w_slip_nxt       = 1'b1;
                w_block_lock_nxt = 1'b0;
                w_lock_drop      = 1'b1;
                w_sh_cnt_nxt     = '0;
                w_sh_invld_nxt   = '0;
                w_slip_wait_nxt  = WaitW'(SLIP_WAIT_N);
            end else if (w_sh_cnt_inc == ShCntW'(SH_CNT_N)) begin
                w_sh_cnt_nxt   = '0;
                w_sh_invld_nxt = '0;
            end else begin
                w_sh_cnt_nxt   = w_sh_cnt_inc;
                w_sh_invld_nxt = w_sh_invld_inc;
            end
        end
    end

    // Marker recognition: control header, known M0-M2, and bytes 4-6 inverted
    always_comb begin
        w_am_match = 1'b0;
        w_am_id    = '0;
        if ((head_i == HeadCtrl) && (data_i[55:32] == ~data_i[23:0])) begin
            for (int unsigned i = 0; i < AmLaneN; i++) begin
                if (data_i[23:0] == am_pattern(i)) begin
                    w_am_match = 1'b1;
                    w_am_id    = LaneW'(i);
                end
            end
        end
    end

    // Marker lock FSM: search, confirm one period later, then track misses
    always_comb begin
        w_am_state_nxt = r_am_state;
        w_pos_nxt      = r_pos;
        w_cand_id_nxt  = r_cand_id;
        w_miss_cnt_nxt = r_miss_cnt;
        w_am_lock_nxt  = r_am_lock;
        w_lane_id_nxt  = r_lane_id;
        w_am_v_nxt     = 1'b0;
        if (w_lock_drop) begin
            w_am_state_nxt = AmSearch;
            w_am_lock_nxt  = 1'b0;
            w_miss_cnt_nxt = '0;
            w_pos_nxt      = '0;
        end else if (valid_i && r_block_lock) begin
            case (r_am_state)
                AmSearch: begin
                    if (w_am_match) begin
                        w_cand_id_nxt  = w_am_id;
                        w_pos_nxt      = '0;
                        w_am_state_nxt = AmConfirm;
                        w_am_v_nxt     = 1'b1;
                    end
                end
                AmConfirm: begin
                    if (!w_pos_exp) begin
                        w_pos_nxt = r_pos + PosW'(1);
                    end else if (w_am_match && (w_am_id == r_cand_id)) begin
                        w_am_state_nxt = AmLocked;
                        w_am_lock_nxt  = 1'b1;
                        w_lane_id_nxt  = r_cand_id;
                        w_miss_cnt_nxt = '0;
                        w_am_v_nxt     = 1'b1;
                        w_pos_nxt      = '0;
                    end else begin
                        w_am_state_nxt = AmSearch;
                    end
                end
                AmLocked: begin
                    if (!w_pos_exp) begin
                        w_pos_nxt = r_pos + PosW'(1);
                    end else begin
                        w_pos_nxt = '0;
                        if (w_am_match && (w_am_id == r_cand_id)) begin
                            w_miss_cnt_nxt = '0;
                            w_am_v_nxt     = 1'b1;
                        end else if (r_miss_cnt == 2'd3) begin
                            w_miss_cnt_nxt = '0;
                            w_am_lock_nxt  = 1'b0;
                            w_am_state_nxt = AmSearch;
                        end else begin
                            w_miss_cnt_nxt = r_miss_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    w_am_state_nxt = AmSearch;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_valid      <= 1'b0;
            r_head       <= '0;
            r_data       <= '0;
            r_slip       <= 1'b0;
            r_block_lock <= 1'b0;
            r_sh_cnt     <= '0;
            r_sh_invld   <= '0;
            r_slip_wait  <= '0;
            r_am_state   <= AmSearch;
            r_pos        <= '0;
            r_cand_id    <= '0;
            r_miss_cnt   <= '0;
            r_am_lock    <= 1'b0;
            r_lane_id    <= '0;
            r_am_v       <= 1'b0;
        end else begin
            r_valid      <= valid_i;
            if (valid_i) begin
                r_head <= head_i;
                r_data <= data_i;
            end
            r_slip       <= w_slip_nxt;
            r_block_lock <= w_block_lock_nxt;
            r_sh_cnt     <= w_sh_cnt_nxt;
            r_sh_invld   <= w_sh_invld_nxt;
            r_slip_wait  <= w_slip_wait_nxt;
            r_am_state   <= w_am_state_nxt;
            r_pos        <= w_pos_nxt;
            r_cand_id    <= w_cand_id_nxt;
            r_miss_cnt   <= w_miss_cnt_nxt;
            r_am_lock    <= w_am_lock_nxt;
            r_lane_id    <= w_lane_id_nxt;
            r_am_v       <= w_am_v_nxt;
        end
    end

`ifdef PCS_RX_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating invalid-header count while locked; cleared when lock falls
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_err_cnt <= '0;
        end else if (w_lock_drop) begin
            r_err_cnt <= '0;
        end else if (w_eval && r_block_lock && !w_hdr_ok && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

    assign valid_o      = r_valid;
    assign head_o       = r_head;
    assign data_o       = r_data;
    assign slip_o       = r_slip;
    assign block_lock_o = r_block_lock;
    assign am_lock_o    = r_am_lock;
    assign lane_id_o    = r_lane_id;
    assign am_v_o       = r_am_v;

endmodule

// File: tb/tb_pcs_40g_rx_lane_sync.sv
// Scoreboard bench for pcs_40g_rx_lane_sync with a shortened marker period
// (AM_SPACING = 15). The driver queues the hand-derived expected output for
// every valid block; the monitor checks each block as it appears on valid_o.
`timescale 1ns/1ps
module tb_pcs_40g_rx_lane_sync;

    localparam logic [1:0]  HData  = 2'b01;
    localparam logic [1:0]  HCtrl  = 2'b10;
    localparam logic [1:0]  HBad   = 2'b00;
    // Byte 0 in [7:0]; BIP bytes zero
    localparam logic [63:0] Am2    = 64'h00_64_9A_3A_00_9B_65_C5;
    localparam logic [63:0] Am2Bad = 64'h00_64_9A_00_00_9B_65_C5;
    localparam logic [63:0] Am1    = 64'h00_19_3B_0F_00_E6_C4_F0;

    logic        clk = 1'b0;
    logic        nreset;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        slip_o;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        block_lock_o;
    logic        am_lock_o;
    logic [1:0]  lane_id_o;
    logic        am_v_o;
`ifdef PCS_RX_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    always #5 clk = ~clk;

    pcs_40g_rx_lane_sync #(
        .LANE_N      (4),
        .DATA_W      (64),
        .HEAD_W      (2),
        .AM_SPACING  (15),
        .SH_CNT_N    (64),
        .SH_INVLD_N  (16),
        .SLIP_WAIT_N (2)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .valid_i      (valid_i),
        .head_i       (head_i),
        .data_i       (data_i),
        .slip_o       (slip_o),
        .valid_o      (valid_o),
        .head_o       (head_o),
        .data_o       (data_o),
        .block_lock_o (block_lock_o),
        .am_lock_o    (am_lock_o),
        .lane_id_o    (lane_id_o),
        .am_v_o       (am_v_o)
`ifdef PCS_RX_ERR_CNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    typedef struct {
        int          idx;
        logic [1:0]  head;
        logic [63:0] data;
        logic        lock;
        logic        am_lock;
        logic [1:0]  id;
        logic        am_v;
        logic        slip;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          blk_no  = 0;
    logic        mon_en  = 1'b0;
    logic [63:0] last_data = '0;
    logic        prev_slip = 1'b0;
    // Expected status levels, set by the scenario ahead of the block that changes them
    logic        e_lock = 1'b0;
    logic        e_am   = 1'b0;
    logic [1:0]  e_id   = 2'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare each output block against the front of the queue
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_block: valid_o=1 with nothing queued");
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("head@%0d", e.idx), head_o, e.head);
                    check($sformatf("data@%0d", e.idx), data_o, e.data);
                    check($sformatf("block_lock@%0d", e.idx), block_lock_o, e.lock);
                    check($sformatf("am_lock@%0d", e.idx), am_lock_o, e.am_lock);
                    check($sformatf("lane_id@%0d", e.idx), lane_id_o, e.id);
                    check($sformatf("am_v@%0d", e.idx), am_v_o, e.am_v);
                    check($sformatf("slip@%0d", e.idx), slip_o, e.slip);
                    check($sformatf("slip_repeat@%0d", e.idx), prev_slip & slip_o, 1'b0);
                    last_data = e.data;
                end
            end else begin
                check("idle_am_v", am_v_o, 1'b0);
                check("idle_slip", slip_o, 1'b0);
                check("idle_data_hold", data_o, last_data);
            end
            prev_slip = slip_o;
        end
    end

    task automatic blk(input logic [1:0] h, input logic [63:0] d, input logic av,
                       input logic sl);
        exp_t e;
        @(negedge clk);
        valid_i = 1'b1;
        head_i  = h;
        data_i  = d;
        blk_no++;
        e.idx = blk_no; e.head = h; e.data = d; e.lock = e_lock; e.am_lock = e_am;
        e.id = e_id; e.am_v = av; e.slip = sl;
        exp_q.push_back(e);
    endtask

    task automatic data_blks(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) begin
            blk(h, 64'hDA7A_0000_0000_0000 | 64'(blk_no), 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            head_i  = 2'($urandom);
            data_i  = {$urandom, $urandom};
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_slip"}, slip_o, 1'b0);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_head"}, head_o, 2'b00);
        check({tag, "_data"}, data_o, 64'd0);
        check({tag, "_block_lock"}, block_lock_o, 1'b0);
        check({tag, "_am_lock"}, am_lock_o, 1'b0);
        check({tag, "_lane_id"}, lane_id_o, 2'd0);
        check({tag, "_am_v"}, am_v_o, 1'b0);
    endtask

    initial begin
        nreset  = 1'b0;
        valid_i = 1'b1;
        head_i  = HBad;
        data_i  = '1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("rst");
        end
        nreset  = 1'b1;
        valid_i = 1'b0;
        mon_en  = 1'b1;

        // Reset then lock on the 64th good header
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) e_lock = 1'b1;
            data_blks(1, HData);
        end

        // Marker lock on lane 2: first marker confirms, second locks
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);
        e_am = 1'b1; e_id = 2'd2;
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);

        // Misplaced lane1 marker at pos 7 plus idle gaps
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(7, HData);
        blk(HCtrl, Am1, 1'b0, 1'b0); idle(2); data_blks(3, HData); idle(1); data_blks(4, HData);
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);

        // Three misses keep marker lock, a good marker clears the miss count
        repeat (3) begin
            blk(HCtrl, Am2Bad, 1'b0, 1'b0); data_blks(15, HData);
        end
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);

        // Four consecutive misses drop marker lock; lane_id holds
        repeat (3) begin
            blk(HCtrl, Am2Bad, 1'b0, 1'b0); data_blks(15, HData);
        end
        e_am = 1'b0;
        blk(HCtrl, Am2Bad, 1'b0, 1'b0); data_blks(15, HData);

        // Re-acquire marker lock
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);
        e_am = 1'b1;
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);

        // 15 bad headers inside one window: lock held (window blocks 33..48)
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HBad);
        blk(HCtrl, Am2, 1'b1, 1'b0); data_blks(15, HData);

        // 16 bad headers inside the next window: lock drops on the 16th with a slip
        blk(HCtrl, Am2, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                e_lock = 1'b0;
                e_am   = 1'b0;
            end
            blk(HBad, 64'hBAD0_0000_0000_0000 | 64'(i), 1'b0, (i == 16));
        end

        // Slip-wait discards two blocks, then unlocked slip on a single bad header
        data_blks(2, HBad);
        data_blks(10, HData);
        blk(HBad, 64'h5119_0000_0000_0001, 1'b0, 1'b1);
        idle(1);
        data_blks(2, HBad);
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) e_lock = 1'b1;
            data_blks(1, HData);
        end
        idle(3);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_left", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation clears everything on the next edge
        mon_en  = 1'b0;
        @(negedge clk);
        nreset  = 1'b0;
        valid_i = 1'b1;
        head_i  = HCtrl;
        data_i  = Am2;
        @(negedge clk);
        check_all_zero("midrst");
        nreset  = 1'b1;
        valid_i = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
